mipsfpga_ahb_keypadscan: RTL and testbench
==========================================

Name: mipsfpga_ahb_keypadscan

Overview:
Scanner for a 4x4 matrix keypad (Pmod KYPD class), on the input side of the board I/O; it is the counterpart of the multiplexed seven-segment output scanner. It drives one active-low column at a time and samples active-low rows through a synchroniser. Each full sweep is debounced, and each new key press is encoded and queued in a small show-ahead FIFO. The AHB GPIO wrapper pops that FIFO as a memory-mapped key register.

Parameters:
SCAN_DIV_W, 16, prescaler width; one column step every 2^SCAN_DIV_W clk cycles
DEBOUNCE_SCANS, 4, identical consecutive frames required before the debounced state updates (range 2-15)
FIFO_DEPTH, 4, key event FIFO entries (power of 2, at least 2)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
COL  output  4  column drive, active-low, exactly one bit low
ROW  input  4  row sense, active-low, externally pulled up, asynchronous
KEY_DATA  output  4  key code at FIFO head; 0 when empty
KEY_VALID  output  1  FIFO not empty
KEY_RD  input  1  pop strobe, one cycle
KEY_DOWN  output  1  at least one key in the debounced state is pressed
OVERFLOW  output  1  sticky flag: a key event was dropped because the FIFO was full
OVF_CLR  input  1  clears OVERFLOW

Behaviour:
- Clock and reset: one clock, clk. Reset resetn is asynchronous and active-low, and all flops reset on it.
- Reset values: COL=4'b1110, KEY_DATA=0, KEY_VALID=0, KEY_DOWN=0, OVERFLOW=0, prescaler=0, column index=0, sync flops=4'hF, debounced state=all released, stable count=0, FIFO empty.
- ROW goes through a 2-flop synchroniser before any use.
- Prescaler: free-running SCAN_DIV_W-bit counter; tick when it equals all-ones.
- On each tick:
  - sample the synchronised rows into the frame bits for the current column: bit index = row*4+col, 1 = pressed;
  - then advance the column index modulo 4;
  - COL updates the next cycle, so each column settles for a full prescaler period.
- Frame complete: the tick that samples column 3.
- Debounce FSM, states SCAN -> EVAL -> (PUSH) -> SCAN.
  - SCAN: accumulate the frame; go to EVAL at frame complete.
  - EVAL, one cycle:
    - if frame == previous frame, stable count increments, saturating at DEBOUNCE_SCANS; otherwise stable count = 1;
    - previous frame <= frame;
    - if stable count (post-update) == DEBOUNCE_SCANS and frame != debounced, then debounced <= frame and new_press = frame & ~debounced_old;
    - go to PUSH if new_press != 0, else SCAN.
  - PUSH, one cycle: enqueue the lowest set index of new_press; any other simultaneous new presses are discarded. Return to SCAN.
  - Scanning continues during EVAL and PUSH; the frame register is not modified by EVAL or PUSH.
- Releases never generate events. KEY_DOWN = OR of the debounced state, registered.
- FIFO: show-ahead.
  - KEY_VALID rises the cycle after PUSH; KEY_DATA shows the head.
  - KEY_RD while KEY_VALID pops; KEY_RD while empty is ignored.
  - Push while full and no pop: event dropped, OVERFLOW set.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - OVERFLOW set and OVF_CLR in the same cycle: set wins.
- Reset mid-operation: everything returns to reset values. Keys still held are re-detected as new presses after DEBOUNCE_SCANS frames.

Optional Feature:
KEYPAD_LEGEND_MAP_EN.
- Defined: the encoder maps index to the printed legend. Row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = 0,F,E,D. Codes are hex values.
- Undefined: KEY_DATA = raw index (row*4+col).
- The mapping is applied before the FIFO write; FIFO contents are always final codes.

Decomposition:
- Shared package/include holds:
  - KP_ROWS=4, KP_COLS=4;
  - FSM state encodings;
  - the 16-entry legend table constant.
- One sub-module, keypad_event_fifo: a parameterised show-ahead FIFO with push/pop/full/empty and an overflow pulse output.

Test Plan:
(All cases use SCAN_DIV_W=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4, map off unless stated.)
- Reset/scan: release resetn -> COL=1110, advancing 1101,1011,0111,1110 every 16 cycles; all outputs 0.
- Single press: hold the row1/col2 contact (model ROW from COL) for 4 frames -> exactly one event, KEY_DATA=6, KEY_VALID=1, KEY_DOWN=1. KEY_RD -> KEY_VALID=0. Release -> KEY_DOWN=0, no event.
- Bounce: toggle the key every 20 cycles for 3 frames, then hold -> a single event after 2 stable frames; none during bouncing.
- Legend map (KEYPAD_LEGEND_MAP_EN defined): press row3/col0 -> KEY_DATA=0; press row3/col3 -> KEY_DATA=D.
- Overflow: 5 distinct press/release pairs with no KEY_RD -> 4 entries in order, OVERFLOW=1. OVF_CLR -> 0. Then KEY_RD in the same cycle as a push while full -> no overflow.
- Simultaneous keys: press indices 5 and 9 together -> one event with code 5. Assert resetn low mid-hold -> FIFO cleared; after release of reset a new event with code 5.

Source files
------------

// File: rtl/mipsfpga_ahb_keypadscan_pkg.sv
// Shared constants, FSM encoding and key-code helpers for the keypad scanner.
// Honours KEYPAD_LEGEND_MAP_EN: when defined, key codes follow the printed legend.
package mipsfpga_ahb_keypadscan_pkg;

   localparam int unsigned KP_ROWS = 4;
   localparam int unsigned KP_COLS = 4;
   localparam int unsigned KP_KEYS = KP_ROWS * KP_COLS;

   typedef enum logic [1:0] {
      StScan = 2'd0,
      StEval = 2'd1,
      StPush = 2'd2
   } kp_state_e;

   // Nibble i is the legend for index row*4+col; rows read 123A / 456B / 789C / 0FED.
   localparam logic [4*KP_KEYS-1:0] KP_LEGEND = 64'hDEF0_C987_B654_A321;

   function automatic logic [3:0] kp_lowest_index(input logic [KP_KEYS-1:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = KP_KEYS - 1; i >= 0; i--) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   function automatic logic [3:0] kp_encode(input logic [3:0] idx);
`ifdef KEYPAD_LEGEND_MAP_EN
      return KP_LEGEND[{idx, 2'b00} +: 4];
`else
      return idx;
`endif
   endfunction

endpackage

// File: rtl/mipsfpga_ahb_keypadscan_fifo.sv
// Show-ahead event FIFO: head is visible on rdata whenever not empty.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module keypad_event_fifo #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             overflow
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      count_q;
   logic             full, do_push, do_pop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL_CNT);
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign overflow = push & full & ~do_pop;
   assign rdata    = empty ? '0 : mem_q[rptr_q];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= wdata;
            wptr_q        <= wptr_q + 1'b1;
         end
         if (do_pop) rptr_q <= rptr_q + 1'b1;
         if (do_push && !do_pop) count_q <= count_q + 1'b1;
         else if (!do_push && do_pop) count_q <= count_q - 1'b1;
      end
   end

endmodule

// File: rtl/mipsfpga_ahb_keypadscan.sv
// 4x4 keypad scanner: column sweep, frame debounce, new-press events into a FIFO.
// Define KEYPAD_LEGEND_MAP_EN to emit printed-legend codes instead of raw indices.
module mipsfpga_ahb_keypadscan
   import mipsfpga_ahb_keypadscan_pkg::*;
#(
   parameter int unsigned SCAN_DIV_W     = 16,
   parameter int unsigned DEBOUNCE_SCANS = 4,
   parameter int unsigned FIFO_DEPTH     = 4
) (
   input  logic       clk,
   input  logic       resetn,
   output logic [3:0] COL,
   input  logic [3:0] ROW,
   output logic [3:0] KEY_DATA,
   output logic       KEY_VALID,
   input  logic       KEY_RD,
   output logic       KEY_DOWN,
   output logic       OVERFLOW,
   input  logic       OVF_CLR
);

   localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE_SCANS);

   logic [3:0]            row_meta_q, row_sync_q;
   logic [SCAN_DIV_W-1:0] div_q;
   logic [1:0]            col_idx_q;
   logic                  tick;
   logic [KP_KEYS-1:0]    frame_q, frame_d, prev_q, prev_d, deb_q, deb_d, newp_q, newp_d;
   logic [3:0]            stable_q, stable_d;
   kp_state_e             state_q, state_d;
   logic                  push, fifo_empty, fifo_ovf, keydown_q, ovf_q;

   assign tick = &div_q;
   assign COL  = ~(4'b0001 << col_idx_q);

   always_comb begin
      frame_d = frame_q;
      if (tick) begin
         for (int r = 0; r < int'(KP_ROWS); r++) frame_d[{2'(r), col_idx_q}] = ~row_sync_q[r];
      end
   end

   always_comb begin
      state_d  = state_q;
      stable_d = stable_q;
      prev_d   = prev_q;
      deb_d    = deb_q;
      newp_d   = newp_q;
      push     = 1'b0;
      unique case (state_q)
         StScan: if (tick && col_idx_q == 2'd3) state_d = StEval;
         StEval: begin
            prev_d = frame_q;
            if (frame_q == prev_q) stable_d = (stable_q == DEB_MAX) ? DEB_MAX : stable_q + 4'd1;
            else stable_d = 4'd1;
            newp_d = '0;
            if (stable_d == DEB_MAX && frame_q != deb_q) begin
               deb_d  = frame_q;
               newp_d = frame_q & ~deb_q;
            end
            state_d = (newp_d != '0) ? StPush : StScan;
         end
         StPush: begin
            push    = 1'b1;
            state_d = StScan;
         end
         default: state_d = StScan;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         row_meta_q <= 4'hF;
         row_sync_q <= 4'hF;
         div_q      <= '0;
         col_idx_q  <= '0;
         frame_q    <= '0;
         prev_q     <= '0;
         deb_q      <= '0;
         newp_q     <= '0;
         stable_q   <= '0;
         state_q    <= StScan;
         keydown_q  <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         row_meta_q <= ROW;
         row_sync_q <= row_meta_q;
         div_q      <= div_q + 1'b1;
         if (tick) col_idx_q <= col_idx_q + 2'd1;
         frame_q    <= frame_d;
         prev_q     <= prev_d;
         deb_q      <= deb_d;
         newp_q     <= newp_d;
         stable_q   <= stable_d;
         state_q    <= state_d;
         keydown_q  <= |deb_q;
         // A drop in the same cycle as a clear keeps the flag set.
         if (fifo_ovf) ovf_q <= 1'b1;
         else if (OVF_CLR) ovf_q <= 1'b0;
      end
   end

   keypad_event_fifo #(
      .WIDTH(4),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push    (push),
      .wdata   (kp_encode(kp_lowest_index(newp_q))),
      .pop     (KEY_RD),
      .rdata   (KEY_DATA),
      .empty   (fifo_empty),
      .overflow(fifo_ovf)
   );

   assign KEY_VALID = ~fifo_empty;
   assign KEY_DOWN  = keydown_q;
   assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_mipsfpga_ahb_keypadscan.sv
// Directed bench for the keypad scanner; the keypad is modelled from COL and a key mask.
module tb_mipsfpga_ahb_keypadscan;

   logic        clk = 1'b0;
   logic        resetn;
   logic [3:0]  COL, ROW, KEY_DATA;
   logic        KEY_VALID, KEY_RD, KEY_DOWN, OVERFLOW, OVF_CLR;
   logic [15:0] keys;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   // Closed contact row r/col c pulls row r low while column c is driven low.
   always_comb begin
      ROW = 4'hF;
      for (int r = 0; r < 4; r++) ROW[r] = ~|(keys[r*4 +: 4] & ~COL);
   end

   mipsfpga_ahb_keypadscan #(
      .SCAN_DIV_W(4),
      .DEBOUNCE_SCANS(2),
      .FIFO_DEPTH(4)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .COL      (COL),
      .ROW      (ROW),
      .KEY_DATA (KEY_DATA),
      .KEY_VALID(KEY_VALID),
      .KEY_RD   (KEY_RD),
      .KEY_DOWN (KEY_DOWN),
      .OVERFLOW (OVERFLOW),
      .OVF_CLR  (OVF_CLR)
   );

   function automatic logic [7:0] exp_code(input int idx);
      logic [3:0] legend [16];
      legend = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                 4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
`ifdef KEYPAD_LEGEND_MAP_EN
      return {4'h0, legend[idx]};
`else
      return 8'(idx);
`endif
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_col(input logic [3:0] target);
      int n;
      n = 0;
      while (COL !== target && n < 200) begin
         cyc(1);
         n++;
      end
      check("wait_col", {4'h0, COL}, {4'h0, target});
   endtask

   task automatic pop;
      KEY_RD = 1'b1;
      cyc(1);
      KEY_RD = 1'b0;
   endtask

   initial begin
      int ids [4];
      keys    = '0;
      KEY_RD  = 1'b0;
      OVF_CLR = 1'b0;
      resetn  = 1'b0;
      cyc(3);
      resetn = 1'b1;

      // Reset values and column sweep
      check("rst_col", {4'h0, COL}, 8'h0E);
      check("rst_valid", {7'h0, KEY_VALID}, 8'h00);
      check("rst_data", {4'h0, KEY_DATA}, 8'h00);
      check("rst_down", {7'h0, KEY_DOWN}, 8'h00);
      check("rst_ovf", {7'h0, OVERFLOW}, 8'h00);
      cyc(15);
      check("col0_hold", {4'h0, COL}, 8'h0E);
      cyc(1);
      check("col1", {4'h0, COL}, 8'h0D);
      cyc(16);
      check("col2", {4'h0, COL}, 8'h0B);
      cyc(16);
      check("col3", {4'h0, COL}, 8'h07);
      cyc(16);
      check("col_wrap", {4'h0, COL}, 8'h0E);

      // Single press row1/col2
      keys = 16'h0040;
      cyc(256);
      check("single_valid", {7'h0, KEY_VALID}, 8'h01);
      check("single_data", {4'h0, KEY_DATA}, exp_code(6));
      check("single_down", {7'h0, KEY_DOWN}, 8'h01);
      pop();
      check("single_popped", {7'h0, KEY_VALID}, 8'h00);
      keys = '0;
      cyc(256);
      check("release_down", {7'h0, KEY_DOWN}, 8'h00);
      check("release_noevt", {7'h0, KEY_VALID}, 8'h00);

      // Bounce aligned to a frame boundary, then steady hold
      wait_col(4'b0111);
      wait_col(4'b1110);
      for (int i = 0; i < 10; i++) begin
         keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
         cyc(20);
      end
      check("bounce_quiet", {7'h0, KEY_VALID}, 8'h00);
      keys = 16'h0040;
      cyc(100);
      check("bounce_valid", {7'h0, KEY_VALID}, 8'h01);
      check("bounce_data", {4'h0, KEY_DATA}, exp_code(6));
      pop();
      check("bounce_single", {7'h0, KEY_VALID}, 8'h00);
      keys = '0;
      cyc(256);

      // Legend corners row3/col0 and row3/col3
      keys = 16'h1000;
      cyc(256);
      check("legend_r3c0", {4'h0, KEY_DATA}, exp_code(12));
      pop();
      keys = '0;
      cyc(256);
      keys = 16'h8000;
      cyc(256);
      check("legend_r3c3", {4'h0, KEY_DATA}, exp_code(15));
      pop();
      keys = '0;
      cyc(256);

      // Five events with no reads: last one dropped
      for (int k = 0; k < 5; k++) begin
         keys = 16'(1 << k);
         cyc(256);
         keys = '0;
         cyc(256);
      end
      check("ovf_set", {7'h0, OVERFLOW}, 8'h01);
      check("ovf_valid", {7'h0, KEY_VALID}, 8'h01);
      check("ovf_head", {4'h0, KEY_DATA}, exp_code(0));
      OVF_CLR = 1'b1;
      cyc(1);
      OVF_CLR = 1'b0;
      check("ovf_clr", {7'h0, OVERFLOW}, 8'h00);

      // Pop lands in the push cycle while full: both happen, no drop
      wait_col(4'b0111);
      wait_col(4'b1110);
      keys = 16'h0080;
      cyc(129);
      pop();
      check("pushpop_noovf", {7'h0, OVERFLOW}, 8'h00);
      ids = '{1, 2, 3, 7};
      for (int i = 0; i < 4; i++) begin
         check("fifo_order", {4'h0, KEY_DATA}, exp_code(ids[i]));
         pop();
      end
      check("fifo_drained", {7'h0, KEY_VALID}, 8'h00);
      keys = '0;
      cyc(256);

      // Simultaneous 5 and 9, then reset mid-hold
      keys = 16'h0220;
      cyc(256);
      check("simul_valid", {7'h0, KEY_VALID}, 8'h01);
      check("simul_data", {4'h0, KEY_DATA}, exp_code(5));
      check("simul_down", {7'h0, KEY_DOWN}, 8'h01);
      resetn = 1'b0;
      cyc(2);
      check("midrst_valid", {7'h0, KEY_VALID}, 8'h00);
      check("midrst_data", {4'h0, KEY_DATA}, 8'h00);
      check("midrst_down", {7'h0, KEY_DOWN}, 8'h00);
      check("midrst_col", {4'h0, COL}, 8'h0E);
      resetn = 1'b1;
      cyc(256);
      check("redetect_valid", {7'h0, KEY_VALID}, 8'h01);
      check("redetect_data", {4'h0, KEY_DATA}, exp_code(5));
      check("redetect_down", {7'h0, KEY_DOWN}, 8'h01);
      pop();
      check("redetect_single", {7'h0, KEY_VALID}, 8'h00);
      keys = '0;
      cyc(10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
